// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO write-side arbiter and future
// read-side schedulers.
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STATS_W = 32;

  // Index width that stays legal when there is only one requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: the first set request at or after
// last_ptr+1, with wrap, wins.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(last_ptr) + off) % N;
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port among NUM_REQ producers.
// Define FIFO_ARB_STATS_EN to add per-requester saturating beat counters.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8,
  parameter int BCNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wr_data,
  input  logic                     fifo_full,
  output logic                     busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] beat_count
`endif
);

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_e         state;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   last_ptr;
  logic [BCNT_W-1:0]  beat_cnt;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               burst_end;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req      (req_valid),
    .last_ptr (last_ptr),
    .onehot   (pick_oh),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  assign busy         = (state == BURST);
  assign grant        = grant_q;
  assign req_ready    = (busy && !fifo_full) ? grant_q : '0;
  assign fifo_wr_en   = |(req_valid & req_ready);
  assign fifo_wr_data = busy ? req_data[int'(gidx)*WIDTH +: WIDTH] : '0;
  assign burst_end    = fifo_wr_en &&
                        (req_last[gidx] || (beat_cnt == BCNT_W'(MAX_BURST - 1)));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  // NOTE: reset is synchronous and covers all state -- there is no storage
  // array here that could be left unreset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      gidx     <= '0;
      last_ptr <= IDX_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_q  <= pick_oh;
            gidx     <= pick_idx;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          // A stalled or absent beat leaves the counter and the lock untouched.
          if (burst_end) begin
            state    <= IDLE;
            last_ptr <= gidx;
            grant_q  <= '0;
            beat_cnt <= '0;
          end else if (fifo_wr_en) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STATS_W-1:0] cnt [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt[i] <= '0;
      end else if (fifo_wr_en && grant_q[i] && (cnt[i] != '1)) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
    assign beat_count[i*STATS_W +: STATS_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: queue-driven producers, expected beats
// and bursts pushed by the stimulus, popped by a negedge monitor.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 8;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]       req_last = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       grant;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wr_data;
  logic                     fifo_full = 1'b0;
  logic                     busy;
`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*32-1:0]    beat_count;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .grant        (grant),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .beat_count   (beat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [WIDTH-1:0] data; } beat_t;
  typedef struct { int idx; int len; } burst_t;

  logic [WIDTH:0]     pq [NUM_REQ][$];
  beat_t              exp_beats [$];
  burst_t             exp_bursts [$];

  int                 n_total = 0;
  int                 n_pass  = 0;
  logic [NUM_REQ-1:0] acc = '0;
  int                 pops [NUM_REQ];
  bit                 flush = 1'b0;
  bit                 stall_armed = 1'b0;
  int                 stall_after = 0;
  int                 stall_cnt = 0;
  int                 stall_cycles = 0;
  int                 cyc = 0;
  int                 first_wr = -1;
  int                 last_wr = -1;
  int                 cur_len = 0;
  int                 cur_idx = -1;
  bit                 prev_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Producers: each queue front is presented; accepted beats are popped.
  initial begin
    foreach (pops[i]) pops[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (flush) begin
        for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
        stall_cnt = 0;
        flush = 1'b0;
      end else begin
        for (int i = 0; i < NUM_REQ; i++)
          if (acc[i] && pq[i].size() > 0) begin
            void'(pq[i].pop_front());
            pops[i]++;
          end
      end
      if (stall_armed && pops[0] == stall_after) begin
        stall_armed = 1'b0;
        stall_cnt = 5;
      end
      if (stall_cnt > 0) begin
        fifo_full = 1'b1;
        stall_cnt--;
      end else begin
        fifo_full = 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pq[i].size() > 0) begin
          req_valid[i] = 1'b1;
          {req_last[i], req_data[i*WIDTH +: WIDTH]} = pq[i][0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
          req_data[i*WIDTH +: WIDTH] = '0;
        end
      end
    end
  end

  // Monitor: compares every written beat and every completed burst.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      acc = '0;
      cur_len = 0;
      prev_busy = 1'b0;
    end else begin
      acc = req_valid & req_ready;
      if (busy)
        for (int i = 0; i < NUM_REQ; i++) if (grant[i]) cur_idx = i;
      if (!busy)
        check("idle_quiet", 64'({fifo_wr_en, req_ready, grant, fifo_wr_data}), 64'd0);
      if (fifo_full) begin
        check("stall_ready", 64'(req_ready), 64'd0);
        check("stall_wr_en", 64'(fifo_wr_en), 64'd0);
        if (busy) stall_cycles++;
      end
      if (fifo_wr_en) begin
        if (exp_beats.size() == 0) begin
          check("beat_unexpected", 64'(fifo_wr_data), 64'hDEAD_0000_0000);
        end else begin
          beat_t e;
          e = exp_beats.pop_front();
          check("beat_data", 64'(fifo_wr_data), 64'(e.data));
          check("beat_grant", 64'(grant), 64'(1) << e.idx);
        end
        cur_len++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (prev_busy && !busy) begin
        if (exp_bursts.size() == 0) begin
          check("burst_unexpected", 64'(cur_len), 64'd0);
        end else begin
          burst_t b;
          b = exp_bursts.pop_front();
          check("burst_owner", 64'(cur_idx), 64'(b.idx));
          check("burst_len", 64'(cur_len), 64'(b.len));
        end
        cur_len = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    foreach (pops[i]) pops[i] = 0;
  endtask

  task automatic send(input int r, input int n, input logic [WIDTH-1:0] base, input bit last_end);
    for (int k = 0; k < n; k++)
      pq[r].push_back({(last_end && k == n - 1), base + WIDTH'(k)});
  endtask

  task automatic expect_burst(input int r, input int n, input logic [WIDTH-1:0] base);
    exp_bursts.push_back('{r, n});
    for (int k = 0; k < n; k++) exp_beats.push_back('{r, base + WIDTH'(k)});
  endtask

  task automatic wait_drain(input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      #1;
      done = !busy && exp_beats.size() == 0 && exp_bursts.size() == 0;
      for (int i = 0; i < NUM_REQ; i++) if (pq[i].size() > 0) done = 1'b0;
    end
    if (!done) check("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    check("rst_wr_data", 64'(fifo_wr_data), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);

    // Single requester 2, three beats A0..A2
    sync();
    send(2, 3, 32'hA0, 1'b1);
    expect_burst(2, 3, 32'hA0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t1_grant", 64'(grant), 64'b0100);
    repeat (2) @(negedge clk);
    check("t1_busy_a2", 64'(busy), 64'd1);
    @(negedge clk);
    check("t1_busy_after", 64'(busy), 64'd0);
    wait_drain(50);

    // All four continuously valid, no last: 0,1,2,3,0 with 8 beats each
    do_reset();
    sync();
    first_wr = -1;
    send(0, 16, 32'h1000, 1'b0);
    send(1, 8, 32'h2000, 1'b0);
    send(2, 8, 32'h3000, 1'b0);
    send(3, 8, 32'h4000, 1'b0);
    expect_burst(0, 8, 32'h1000);
    expect_burst(1, 8, 32'h2000);
    expect_burst(2, 8, 32'h3000);
    expect_burst(3, 8, 32'h4000);
    expect_burst(0, 8, 32'h1008);
    wait_drain(200);
    check("t2_span", 64'(last_wr - first_wr), 64'd43);

    // FIFO full for 5 cycles after three beats; counter must hold
    do_reset();
    sync();
    stall_cycles = 0;
    stall_after = 3;
    stall_armed = 1'b1;
    send(0, 10, 32'h6000, 1'b1);
    expect_burst(0, 8, 32'h6000);
    expect_burst(0, 2, 32'h6008);
    wait_drain(200);
    check("t3_stall_cycles", 64'(stall_cycles), 64'd5);

    // Fairness after wrap: last_ptr=3, requesters 1 and 3
    do_reset();
    sync();
    send(1, 2, 32'h5100, 1'b1);
    send(3, 2, 32'h5300, 1'b1);
    expect_burst(1, 2, 32'h5100);
    expect_burst(3, 2, 32'h5300);
    wait_drain(100);

    // Reset during beat 4 of requester 2's burst
    do_reset();
    sync();
    send(2, 8, 32'hD0, 1'b0);
    for (int k = 0; k < 4; k++) exp_beats.push_back('{2, 32'hD0 + 32'(k)});
    begin
      bit hit = 1'b0;
      for (int c = 0; c < 50 && !hit; c++) begin
        @(posedge clk);
        #2;
        hit = (pops[2] == 4);
      end
      if (!hit) check("t5_beat4_timeout", 64'd0, 64'd1);
    end
    rst_n = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_grant", 64'(grant), 64'd0);
    check("t5_rst_out", 64'({fifo_wr_en, req_ready, fifo_wr_data}), 64'd0);
    check("t5_rst_drop", 64'(exp_beats.size()), 64'd0);
    sync();
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      send(i, 1, 32'hE0 + 32'(i), 1'b1);
      expect_burst(i, 1, 32'hE0 + 32'(i));
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t5_first_grant", 64'(grant), 64'b0001);
    wait_drain(100);

`ifdef FIFO_ARB_STATS_EN
    // 10 beats from requester 1, 3 from requester 3
    do_reset();
    sync();
    send(1, 10, 32'h7100, 1'b1);
    send(3, 3, 32'h7300, 1'b1);
    expect_burst(1, 8, 32'h7100);
    expect_burst(3, 3, 32'h7300);
    expect_burst(1, 2, 32'h7108);
    wait_drain(200);
    check("stats_r0", 64'(beat_count[0*32 +: 32]), 64'd0);
    check("stats_r1", 64'(beat_count[1*32 +: 32]), 64'd10);
    check("stats_r2", 64'(beat_count[2*32 +: 32]), 64'd0);
    check("stats_r3", 64'(beat_count[3*32 +: 32]), 64'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter sharing the single write port of a `sync_fifo` among `NUM_REQ` independent producers. Each producer presents a valid/ready stream. A granted producer holds the FIFO write port for one burst, which ends on `req_last` or after `MAX_BURST` beats. The block sits directly in front of the FIFO write interface and honours its `full` flag, so no beat is ever dropped.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 1–16.
- `WIDTH`, 32: data width in bits; must match the FIFO `WIDTH`.
- `MAX_BURST`, 8: maximum beats per grant; must be ≥1.
- `BCNT_W`, `$clog2(MAX_BURST+1)`: width of the beat counter.

Ports (clock and reset first):
- One clock; reset is synchronous and active-low.
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `req_valid`  in  NUM_REQ  per-requester data valid
- `req_data`  in  NUM_REQ*WIDTH  packed data; requester i occupies `[i*WIDTH +: WIDTH]`
- `req_last`  in  NUM_REQ  final beat of the requester's burst
- `req_ready`  out  NUM_REQ  per-requester accept
- `grant`  out  NUM_REQ  one-hot current owner; all zero when idle
- `fifo_wr_en`  out  1  to FIFO `wr_en`
- `fifo_wr_data`  out  WIDTH  to FIFO `wr_data`
- `fifo_full`  in  1  from FIFO `full`
- `busy`  out  1  high while in BURST

## Operation
- State machine with two states, IDLE and BURST. Reset state is IDLE.
- IDLE:
  - If any `req_valid` is high, select the first requester with valid set, searching from `last_ptr+1` upward with modulo `NUM_REQ` wrap.
  - Register that requester into `grant`, clear `beat_cnt`, and go to BURST.
  - If no `req_valid` is high, stay in IDLE.
- BURST:
  - `req_ready[g] = !fifo_full`. All other `req_ready` bits are 0.
  - `fifo_wr_en = req_valid[g] & req_ready[g]` (combinational).
  - `fifo_wr_data` is the granted slice whenever in BURST, and 0 in IDLE.
- Beat accepted when `fifo_wr_en` is high. On each accepted beat, `beat_cnt` increments.
- Burst termination:
  - A burst ends on an accepted beat with `req_last[g]` high, or on an accepted beat where `beat_cnt == MAX_BURST-1`.
  - On termination: go to IDLE, set `last_ptr <= g`, and clear `grant`.
- If the grantee drops `req_valid` mid-burst, the lock is held; there is no timeout. Producers must complete bursts.
- `fifo_full` high stalls the burst. `req_ready` goes low and `beat_cnt` holds.
- When `NUM_REQ == 1`, the block degenerates to a pass-through, with one idle cycle between bursts.

## Timing
- Values after reset:
  - `grant`, `busy`, `fifo_wr_en`, `fifo_wr_data`, and `req_ready` are all 0.
  - `last_ptr = NUM_REQ-1`, so requester 0 wins first.
- Arbitration latency: a `req_valid` sampled in IDLE at edge N gives `grant` and `busy` high after edge N. The first beat can transfer in that same cycle.
- There is exactly one IDLE bubble cycle between consecutive bursts.
- Peak throughput is `MAX_BURST/(MAX_BURST+1)` beats per cycle.
- `fifo_full` is used combinationally in the same cycle. The FIFO updates `full` one edge after a write, so `full` asserting never causes a lost beat.
- Reset asserted mid-burst forces IDLE at the next edge. Any partially sent burst is abandoned; the FIFO is expected to be reset by the same `rst_n`.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - Adds output `beat_count`, NUM_REQ×32 bits, packed per requester.
  - Each requester's counter increments on every beat accepted from that requester.
  - Counters saturate at `32'hFFFF_FFFF` and clear on reset.
- `FIFO_ARB_STATS_EN` undefined: the port and counters are absent and there is no other behavioural difference.

## Structure
- Shared package `fifo_pkg`:
  - `arb_state_e` enum (IDLE, BURST).
  - `STATS_W = 32` constant.
- Sub-module `rr_pick`:
  - Purely combinational rotate-priority picker.
  - Inputs: request vector and `last_ptr`. Outputs: one-hot winner and index.
  - Reusable by later read-side schedulers.
- The arbiter is instantiated alongside `sync_fifo` in a wrapper. It does not embed the FIFO.

## Test plan
- **Reset, then one requester:**
  - Stimulus: only `req_valid[2]`, 3 beats of 0xA0–0xA2, `last` on the third.
  - Required: `grant = 4'b0100` one cycle later; FIFO receives A0, A1, A2 in order; `busy` drops after the A2 edge.
- **All four requesters continuously valid, `MAX_BURST = 8`, `req_last` never set:**
  - Required: grant sequence 0, 1, 2, 3, 0 with 8 beats each and one bubble between bursts.
- **FIFO full mid-burst:**
  - Stimulus: hold `fifo_full` high for 5 cycles after beat 2.
  - Required: `req_ready` low for those cycles, no `fifo_wr_en`, and the burst resumes at beat 3 with no duplicates.
- **Round-robin fairness after wrap:**
  - Stimulus: `last_ptr = 3`, with requesters 1 and 3 valid.
  - Required: requester 1 wins, then requester 3.
- **Reset mid-burst:**
  - Stimulus: pull `rst_n` low during beat 4 of requester 2's burst.
  - Required: next cycle IDLE with all outputs 0. On release with all requesters valid, requester 0 wins.
- **`FIFO_ARB_STATS_EN` build:**
  - Stimulus: 10 beats from requester 1 and 3 beats from requester 3.
  - Required: `beat_count` slices read 0, 10, 0, 3.
